regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the pipelined cores. Successor to the single-write, two-read decode-stage register file.
- Adds configurable width, depth and port counts, an optional registered-read mode, and an integrated busy-bit scoreboard used by decode for hazard detection.
- Sits between decode (read and issue) and writeback (write and clear). Also provides a debug read port for the simulation harness.

Parameters:
- XLEN, 32, data width in bits.
- REG_NUM, 32, number of architectural registers; power of two, 2..64.
- AW, $clog2(REG_NUM), register address width (derived).
- NR, 2, number of read ports (1..4).
- NW, 1, number of write ports (1..2).
- READ_LAT, 0, read latency: 0 = combinational read, 1 = registered read.
- ZERO_X0, 1, if 1 then x0 is hardwired to zero and is never busy.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- rs_addr_i  in  NR*AW  read addresses; port k occupies bits [k*AW +: AW].
- rs_data_o  out  NR*XLEN  read data, port k.
- rs_busy_o  out  NR  1 = register addressed by port k has a pending writer.
- rd_we_i  in  NW  write enable per write port.
- rd_addr_i  in  NW*AW  write addresses.
- rd_data_i  in  NW*XLEN  write data.
- rd_clr_i  in  NW  1 = this write retires the pending producer (clears busy).
- issue_valid_i  in  1  decode issues an instruction that writes issue_rd_i.
- issue_rd_i  in  AW  destination of the issued instruction.
- dbg_addr_i  in  AW  debug read address.
- dbg_data_o  out  XLEN  debug read data; combinational, never bypassed.

Behaviour:
- Reset (rst_n_i low, asynchronous): all registers = 0, all busy bits = 0, registered rs_data_o = 0. Outputs hold these values until the first rising edge after deassertion.
- Effective write, port w: rd_we_i[w] & !(ZERO_X0 & rd_addr_i[w]==0). The register updates at the rising edge.
- Write collision (NW=2, same address): port 1 wins, for both storage and bypass.
- READ_LAT=0:
  - rs_data_o[k] is combinational.
  - If any effective write targets rs_addr_i[k] this cycle, output the winning write data (write-through bypass); otherwise output stored contents.
- READ_LAT=1:
  - rs_addr_i is sampled at the edge; rs_data_o is valid the following cycle and holds until the next edge.
  - The sampled value includes same-cycle write bypass, so a read issued in the same cycle as a write to that register returns the new data.
- ZERO_X0=1: reads of address 0 return 0 regardless of writes; rs_busy_o for address 0 = 0.
- Address >= REG_NUM cannot occur (REG_NUM is a power of two).
- Scoreboard, one busy bit per register, updated at the edge:
  - Cleared when an effective write has rd_clr_i[w]=1 for that address.
  - Set when issue_valid_i=1 for issue_rd_i (ignored for x0 when ZERO_X0).
  - Set and clear on the same register in the same cycle: set wins (a new producer supersedes).
  - A write with rd_clr_i=0 updates data only and leaves busy unchanged.
- rs_busy_o[k]:
  - Always combinational from the current busy bit of rs_addr_i[k].
  - Masked to 0 if an effective clearing write to that address occurs this cycle (bypass makes data available).
  - Not masked by a same-cycle issue.
- dbg_data_o = stored register contents, no bypass. Reading x0 returns 0 when ZERO_X0.
- Reset asserted mid-operation clears storage and the scoreboard immediately; pending in-flight writes are lost.

Test Plan:
- Reset, then read all 32 registers via dbg_addr_i -> all 0; rs_busy_o = 0.
- NR=2, READ_LAT=0: write x5=0xDEADBEEF with rs_addr port0=5 in the same cycle -> rs_data_o port0 = 0xDEADBEEF that cycle; dbg_data_o shows it the next cycle.
- Write x0=0x1234, then read port1 addr 0 and issue_rd=0 -> data 0, busy 0.
- NW=2: both ports write x7 (0x11 on port 0, 0x22 on port 1) -> x7 = 0x22; same-cycle bypass returns 0x22.
- Issue x9 -> busy[9]=1 next cycle. Write x9=0x55 with clr=1 -> busy masked 0 that cycle and data 0x55. Issue x9 plus clearing write x9 in the same cycle -> busy[9]=1 afterward.
- READ_LAT=1: addr=3 while x3 is written 0xA5 -> rs_data_o=0xA5 one cycle later. Assert rst_n_i low mid-sequence -> outputs 0 immediately and x3 reads 0.

Source files
------------

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bundles the decode/writeback side of the multi-port register file.
//   master : decode + writeback + debug harness (drives addresses, writes, issue)
//   slave  : the register file itself
// Read ports are packed, port k at [k*AW +: AW] / [k*XLEN +: XLEN].
interface regfile_mp_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NR   = 2,
    parameter int NW   = 1
);
    logic [NR*AW-1:0]   rs_addr_i;
    logic [NR*XLEN-1:0] rs_data_o;
    logic [NR-1:0]      rs_busy_o;
    logic [NW-1:0]      rd_we_i;
    logic [NW*AW-1:0]   rd_addr_i;
    logic [NW*XLEN-1:0] rd_data_i;
    logic [NW-1:0]      rd_clr_i;
    logic               issue_valid_i;
    logic [AW-1:0]      issue_rd_i;
    logic [AW-1:0]      dbg_addr_i;
    logic [XLEN-1:0]    dbg_data_o;

    modport master (
        output rs_addr_i, rd_we_i, rd_addr_i, rd_data_i, rd_clr_i,
               issue_valid_i, issue_rd_i, dbg_addr_i,
        input  rs_data_o, rs_busy_o, dbg_data_o
    );

    modport slave (
        input  rs_addr_i, rd_we_i, rd_addr_i, rd_data_i, rd_clr_i,
               issue_valid_i, issue_rd_i, dbg_addr_i,
        output rs_data_o, rs_busy_o, dbg_data_o
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file with busy-bit scoreboard.
//   clk_i    : clock, all state on rising edge
//   rst_n_i  : asynchronous active-low reset (clears storage, scoreboard, read regs)
//   bus      : regfile_mp_if.slave -- NR read ports with write-through bypass,
//              NW write ports (higher port index wins on collision), issue port
//              that marks a destination busy, and a non-bypassed debug read port.
// READ_LAT=0 gives combinational read data, READ_LAT=1 registers the bypassed
// read result so it appears the cycle after the address is presented.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int REG_NUM  = 32,
    parameter int AW       = $clog2(REG_NUM),
    parameter int NR       = 2,
    parameter int NW       = 1,
    parameter int READ_LAT = 0,
    parameter int ZERO_X0  = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    regfile_mp_if.slave  bus
);

    logic [REG_NUM-1:0][XLEN-1:0] r_mem;
    logic [REG_NUM-1:0]           r_busy;

    logic [NW-1:0]      w_wen;
    logic [AW-1:0]      w_ra [NR];
    logic [NR*XLEN-1:0] w_rs_data;
    logic [NR-1:0]      w_rs_busy;
    logic               w_issue_en;

    // Writes to x0 are dropped entirely when x0 is hardwired.
    always_comb begin
        w_wen = '0;
        for (int w = 0; w < NW; w++) begin
            w_wen[w] = bus.rd_we_i[w] &&
                       !((ZERO_X0 != 0) && (bus.rd_addr_i[w*AW +: AW] == '0));
        end
    end

    assign w_issue_en = bus.issue_valid_i &&
                        !((ZERO_X0 != 0) && (bus.issue_rd_i == '0));

    // Loop order matters: a later write port overrides an earlier one, and the
    // issue set comes after all clears so a new producer supersedes retirement.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_mem  <= '0;
            r_busy <= '0;
        end else begin
            for (int w = 0; w < NW; w++) begin
                if (w_wen[w]) begin
                    r_mem[bus.rd_addr_i[w*AW +: AW]] <= bus.rd_data_i[w*XLEN +: XLEN];
                    if (bus.rd_clr_i[w]) begin
                        r_busy[bus.rd_addr_i[w*AW +: AW]] <= 1'b0;
                    end
                end
            end
            if (w_issue_en) begin
                r_busy[bus.issue_rd_i] <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NR; k++) begin
            w_ra[k] = bus.rs_addr_i[k*AW +: AW];
        end
    end

    // Bypass: data follows the winning (highest-index) write; busy is masked by
    // any clearing write to the address, independent of which port wins data.
    always_comb begin
        w_rs_data = '0;
        w_rs_busy = '0;
        for (int k = 0; k < NR; k++) begin
            w_rs_data[k*XLEN +: XLEN] = r_mem[w_ra[k]];
            w_rs_busy[k]              = r_busy[w_ra[k]];
            for (int w = 0; w < NW; w++) begin
                if (w_wen[w] && (bus.rd_addr_i[w*AW +: AW] == w_ra[k])) begin
                    w_rs_data[k*XLEN +: XLEN] = bus.rd_data_i[w*XLEN +: XLEN];
                    if (bus.rd_clr_i[w]) begin
                        w_rs_busy[k] = 1'b0;
                    end
                end
            end
            if ((ZERO_X0 != 0) && (w_ra[k] == '0)) begin
                w_rs_data[k*XLEN +: XLEN] = '0;
                w_rs_busy[k]              = 1'b0;
            end
        end
    end

    generate
        if (READ_LAT == 1) begin : g_rd_reg
            logic [NR*XLEN-1:0] r_rs_data;

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    r_rs_data <= '0;
                end else begin
                    r_rs_data <= w_rs_data;
                end
            end

            assign bus.rs_data_o = r_rs_data;
        end else begin : g_rd_comb
            assign bus.rs_data_o = w_rs_data;
        end
    endgenerate

    assign bus.rs_busy_o  = w_rs_busy;
    assign bus.dbg_data_o = ((ZERO_X0 != 0) && (bus.dbg_addr_i == '0)) ? '0
                                                                        : r_mem[bus.dbg_addr_i];

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (combinational and registered read, both
// with two write ports) driven by the same stimulus, compared against an
// array-based reference model of the architectural registers and busy bits.
module tb_regfile_mp;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [9:0]  rs_addr;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic [1:0]  clr;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  dbga;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] m_mem [32];
    logic        m_busy [32];
    logic [31:0] lat_exp [2];

    always #5 clk_i = ~clk_i;

    regfile_mp_if #(.XLEN(32), .AW(5), .NR(2), .NW(2)) bus0 ();
    regfile_mp_if #(.XLEN(32), .AW(5), .NR(2), .NW(2)) bus1 ();

    assign bus0.rs_addr_i = rs_addr;  assign bus1.rs_addr_i = rs_addr;
    assign bus0.rd_we_i   = we;       assign bus1.rd_we_i   = we;
    assign bus0.rd_addr_i = wa;       assign bus1.rd_addr_i = wa;
    assign bus0.rd_data_i = wd;       assign bus1.rd_data_i = wd;
    assign bus0.rd_clr_i  = clr;      assign bus1.rd_clr_i  = clr;
    assign bus0.issue_valid_i = iv;   assign bus1.issue_valid_i = iv;
    assign bus0.issue_rd_i    = ird;  assign bus1.issue_rd_i    = ird;
    assign bus0.dbg_addr_i    = dbga; assign bus1.dbg_addr_i    = dbga;

    regfile_mp #(.NW(2), .READ_LAT(0)) u_dut0 (.clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bus0));
    regfile_mp #(.NW(2), .READ_LAT(1)) u_dut1 (.clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bus1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic eff(input int w);
        return we[w] && (wa[w*5 +: 5] != 5'd0);
    endfunction

    // Architectural view: x0 reads zero; otherwise the last port writing the
    // address this cycle supplies the data, else the stored value.
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        logic [31:0] v;
        if (a == 5'd0) return 32'd0;
        v = m_mem[a];
        for (int w = 0; w < 2; w++)
            if (eff(w) && wa[w*5 +: 5] == a) v = wd[w*32 +: 32];
        return v;
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        logic b;
        if (a == 5'd0) return 1'b0;
        b = m_busy[a];
        for (int w = 0; w < 2; w++)
            if (eff(w) && clr[w] && wa[w*5 +: 5] == a) b = 1'b0;
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 32'd0;
            m_busy[i] = 1'b0;
        end
        lat_exp[0] = 32'd0;
        lat_exp[1] = 32'd0;
    endtask

    task automatic model_edge();
        for (int w = 0; w < 2; w++) begin
            if (eff(w)) begin
                m_mem[wa[w*5 +: 5]] = wd[w*32 +: 32];
                if (clr[w]) m_busy[wa[w*5 +: 5]] = 1'b0;
            end
        end
        if (iv && ird != 5'd0) m_busy[ird] = 1'b1;
    endtask

    task automatic idle();
        rs_addr = '0; we = '0; wa = '0; wd = '0; clr = '0;
        iv = 1'b0; ird = '0; dbga = '0;
    endtask

    function automatic logic [4:0] raddr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    task automatic rand_inputs();
        for (int k = 0; k < 2; k++) rs_addr[k*5 +: 5] = raddr();
        for (int w = 0; w < 2; w++) begin
            we[w]           = 1'($urandom_range(0, 1));
            wa[w*5 +: 5]    = raddr();
            wd[w*32 +: 32]  = $urandom;
            clr[w]          = 1'($urandom_range(0, 1));
        end
        iv   = ($urandom_range(0, 2) == 0);
        ird  = raddr();
        dbga = raddr();
    endtask

    task automatic check_all();
        logic [4:0] a;
        for (int k = 0; k < 2; k++) begin
            a = rs_addr[k*5 +: 5];
            check("rd_comb",  bus0.rs_data_o[k*32 +: 32], exp_rd(a));
            check("busy_c",   32'(bus0.rs_busy_o[k]), 32'(exp_busy(a)));
            check("busy_r",   32'(bus1.rs_busy_o[k]), 32'(exp_busy(a)));
            check("rd_reg",   bus1.rs_data_o[k*32 +: 32], lat_exp[k]);
        end
        check("dbg_c", bus0.dbg_data_o, (dbga == 5'd0) ? 32'd0 : m_mem[dbga]);
        check("dbg_r", bus1.dbg_data_o, (dbga == 5'd0) ? 32'd0 : m_mem[dbga]);
    endtask

    // Inputs are driven at the falling edge; checks run shortly after, the model
    // advances at the rising edge.
    task automatic cycle();
        logic [31:0] nxt [2];
        #1;
        check_all();
        nxt[0] = exp_rd(rs_addr[4:0]);
        nxt[1] = exp_rd(rs_addr[9:5]);
        @(posedge clk_i);
        model_edge();
        lat_exp[0] = nxt[0];
        lat_exp[1] = nxt[1];
        @(negedge clk_i);
    endtask

    initial begin
        idle();
        model_reset();
        #3;
        check("rst_busy", 32'(bus0.rs_busy_o), 32'd0);
        check("rst_rd_reg", bus1.rs_data_o[31:0], 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Post-reset sweep of all registers through the debug port.
        for (int i = 0; i < 32; i++) begin
            dbga = 5'(i);
            #1 check("rst_dbg", bus0.dbg_data_o, 32'd0);
            cycle();
        end

        // Write-through bypass, then visible on the debug port next cycle.
        idle();
        we = 2'b01; wa[4:0] = 5'd5; wd[31:0] = 32'hDEADBEEF; rs_addr[4:0] = 5'd5;
        #1 check("byp_x5", bus0.rs_data_o[31:0], 32'hDEADBEEF);
        cycle();
        idle(); dbga = 5'd5;
        #1 check("dbg_x5", bus0.dbg_data_o, 32'hDEADBEEF);
        cycle();

        // x0 stays zero and never goes busy.
        idle();
        we = 2'b01; wa[4:0] = 5'd0; wd[31:0] = 32'h1234; rs_addr[9:5] = 5'd0; iv = 1'b1; ird = 5'd0;
        cycle();
        idle(); rs_addr[9:5] = 5'd0;
        #1 check("x0_data", bus0.rs_data_o[63:32], 32'd0);
        check("x0_busy", 32'(bus0.rs_busy_o[1]), 32'd0);
        cycle();

        // Collision: port 1 wins.
        idle();
        we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h22, 32'h11}; rs_addr[4:0] = 5'd7;
        #1 check("coll_byp", bus0.rs_data_o[31:0], 32'h22);
        cycle();
        idle(); dbga = 5'd7;
        #1 check("coll_dbg", bus0.dbg_data_o, 32'h22);
        cycle();

        // Scoreboard set / clear-mask / set-wins.
        idle(); iv = 1'b1; ird = 5'd9;
        cycle();
        idle(); rs_addr[4:0] = 5'd9;
        #1 check("busy9_set", 32'(bus0.rs_busy_o[0]), 32'd1);
        cycle();
        idle(); rs_addr[4:0] = 5'd9; we = 2'b01; wa[4:0] = 5'd9; wd[31:0] = 32'h55; clr = 2'b01;
        #1 check("busy9_mask", 32'(bus0.rs_busy_o[0]), 32'd0);
        check("data9_byp", bus0.rs_data_o[31:0], 32'h55);
        cycle();
        idle(); rs_addr[4:0] = 5'd9; we = 2'b01; wa[4:0] = 5'd9; wd[31:0] = 32'h66; clr = 2'b01;
        iv = 1'b1; ird = 5'd9;
        cycle();
        idle(); rs_addr[4:0] = 5'd9;
        #1 check("busy9_setwin", 32'(bus0.rs_busy_o[0]), 32'd1);
        cycle();

        // Registered read sees same-cycle write one cycle later.
        idle(); rs_addr[4:0] = 5'd3; we = 2'b01; wa[4:0] = 5'd3; wd[31:0] = 32'hA5;
        cycle();
        idle(); rs_addr[4:0] = 5'd3;
        #1 check("lat1_x3", bus1.rs_data_o[31:0], 32'hA5);
        cycle();

        for (int n = 0; n < 400; n++) begin
            rand_inputs();
            cycle();
        end

        // Mid-operation reset clears everything immediately.
        idle(); we = 2'b01; wa[4:0] = 5'd3; wd[31:0] = 32'h3C;
        cycle();
        idle(); rs_addr[4:0] = 5'd3; dbga = 5'd3; iv = 1'b1; ird = 5'd3;
        #1 check("pre_rst_dbg", bus0.dbg_data_o, 32'h3C);
        #1 rst_n_i = 1'b0;
        #1 check("rst_rd_reg3", bus1.rs_data_o[31:0], 32'd0);
        check("rst_dbg3", bus0.dbg_data_o, 32'd0);
        check("rst_busy3", 32'(bus0.rs_busy_o), 32'd0);
        model_reset();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        idle(); rs_addr[4:0] = 5'd3; dbga = 5'd3;
        cycle();

        for (int n = 0; n < 200; n++) begin
            rand_inputs();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
